hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-stage Tnew/write-address decode: tracks every in-flight writer after D in one structure.
- Holds one entry per post-D pipeline stage (E, M, W by default): entry = valid, destination register, remaining Tnew.
- Each cycle it compares the D-stage source registers and their Tuse against the entries, then drives a D-stage stall and per-source D-stage forward selects.
- Sits beside the D/E pipeline registers; the decoder feeds it and the datapath forward muxes consume its outputs.

Parameters:
- STAGES, 3, number of tracked post-D stages (entry 0 = E); legal range 2..7.
- AW, 5, register address width; address 0 is never a hazard.
- TW, 2, Tnew/Tuse width.
- SELW, 3, forward-select width; requires SELW >= clog2(STAGES+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears entry 0 at the next edge (squashes the instruction entering E).
- d_valid  in  1  D stage holds a real instruction.
- d_rs  in  AW  D-stage source register 1.
- d_rt  in  AW  D-stage source register 2.
- d_tuse_rs  in  TW  cycles until rs is needed; only meaningful when d_rs != 0.
- d_tuse_rt  in  TW  cycles until rt is needed; only meaningful when d_rt != 0.
- d_waddr  in  AW  D-stage destination register; 0 = no write.
- d_tnew  in  TW  Tnew of the D instruction when it enters E.
- stall  out  1  freeze PC and F/D; insert a bubble into E.
- fwd_sel_rs  out  SELW  0 = register file; k (1..STAGES) = forward from entry k-1.
- fwd_sel_rt  out  SELW  same encoding, for rt.
- busy_any  out  1  at least one valid entry has tnew != 0.

Behaviour:
- Reset (async, reset=0): all entries valid=0, waddr=0, tnew=0. Outputs combinationally read 0 while reset is held.
- Match rule for a source s: s != 0, entry valid, entry waddr == s. The youngest match wins (lowest index).
- Stall: stall = d_valid && (rs hazard || rt hazard). A source has a hazard when its youngest match has tnew > tuse. Combinational, zero latency.
- Forward select: sel = i+1 when the youngest match is entry i with tnew == 0. Otherwise sel = 0, including the no-match case and the case 0 < tnew <= tuse, which is resolved by later-stage forwarding outside this block.
- Shift on every edge (stall never freezes E onward):
  - entry[k] <= entry[k-1] for k >= 1, with tnew decremented and saturating at 0.
  - entry[STAGES-1] is discarded.
- Entry 0 load priority, highest first:
  - flush: bubble (valid=0).
  - stall: bubble.
  - !d_valid: bubble.
  - d_waddr == 0: loaded with valid=0.
  - otherwise: {1, d_waddr, d_tnew}.
- d_tnew is stored as given and is not decremented on entry.
- Simultaneous flush and stall: bubble (identical result).
- Reset asserted mid-operation clears all entries immediately. Deassertion is sampled by the next edge.

Optional Feature:
- Macro: HAZARD_MDU_EN.
- With the macro, extra ports and parameter:
  - md_start (in 1): the instruction entering E starts a multiply/divide.
  - md_use (in 1): the D instruction reads or writes HI/LO.
  - mdu_busy (out 1).
  - Parameter MDU_LAT, default 5.
- With the macro, a busy counter:
  - Counter loads MDU_LAT when an entry-0 load is accepted with md_start=1 (no stall, no flush).
  - Otherwise it decrements to 0; mdu_busy = (counter != 0).
  - Extra stall term: d_valid && md_use && (mdu_busy || md_start accepted this cycle into E).
  - Reset clears the counter. flush does not clear a counter that is already running.
- Without the macro: no ports, no counter, stall as above.

Test Plan:
- Load-use: entry0 = {1, r8, tnew=1}, D reads r8 with tuse=0 → stall=1 for 1 cycle. Next cycle r8 is in entry1 with tnew=0 → fwd_sel_rs=2, stall=0.
- ALU back-to-back: entry0 = {1, r9, 0}, D rt=r9, tuse=1 → stall=0, fwd_sel_rt=1.
- Youngest wins: entry0 = {1, r5, 0} and entry1 = {1, r5, 0}, D rs=r5 → fwd_sel_rs=1.
- $0 immunity: entry0 = {1, r0, 2}, D rs=r0, tuse=0 → stall=0, fwd_sel_rs=0. Also, d_waddr=0 loads entry0 with valid=0.
- Flush and reset:
  - flush=1 with d_waddr=r3 → next cycle entry0 is invalid; a D read of r3 gives sel=0, stall=0.
  - reset=0 mid-sequence clears all entries and busy_any within the same cycle.
- HAZARD_MDU_EN, MDU_LAT=5: md_start accepted at cycle t → mdu_busy=1 for cycles t+1..t+5. md_use at t+3 → stall=1 through t+5, released at t+6.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: one entry per post-D stage, youngest-match stall and forward-select decode.
// Optional multiply/divide busy tracking is enabled by defining HAZARD_MDU_EN.
module hazard_scoreboard #(
   parameter int STAGES = 3,
   parameter int AW     = 5,
   parameter int TW     = 2,
   parameter int SELW   = 3
`ifdef HAZARD_MDU_EN
   ,
   parameter int MDU_LAT = 5
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            d_valid,
   input  logic [AW-1:0]   d_rs,
   input  logic [AW-1:0]   d_rt,
   input  logic [TW-1:0]   d_tuse_rs,
   input  logic [TW-1:0]   d_tuse_rt,
   input  logic [AW-1:0]   d_waddr,
   input  logic [TW-1:0]   d_tnew,
`ifdef HAZARD_MDU_EN
   input  logic            md_start,
   input  logic            md_use,
   output logic            mdu_busy,
`endif
   output logic            stall,
   output logic [SELW-1:0] fwd_sel_rs,
   output logic [SELW-1:0] fwd_sel_rt,
   output logic            busy_any
);

   logic [STAGES-1:0]         valid_r;
   logic [STAGES-1:0][AW-1:0] waddr_r;
   logic [STAGES-1:0][TW-1:0] tnew_r;

   logic            hit_rs_s, hit_rt_s, haz_rs_s, haz_rt_s;
   logic [TW-1:0]   tnew_rs_s, tnew_rt_s;
   logic [SELW-1:0] sel_rs_s, sel_rt_s, fwd_rs_s, fwd_rt_s;
   logic [STAGES-1:0] busy_vec_s;
   logic            stall_base_s, stall_s, load_s;

   // Scans oldest to youngest so the lowest-index match overrides: returns {hit, tnew, sel}.
   function automatic logic [SELW+TW:0] youngest_match(
      input logic [AW-1:0]               src,
      input logic [STAGES-1:0]           valid,
      input logic [STAGES-1:0][AW-1:0]   waddr,
      input logic [STAGES-1:0][TW-1:0]   tnew
   );
      logic            hit;
      logic            m;
      logic [TW-1:0]   tn;
      logic [SELW-1:0] sel;
      hit = 1'b0;
      tn  = {TW{1'b0}};
      sel = {SELW{1'b0}};
      for (int i = STAGES - 1; i >= 0; i--) begin
         m   = (src != {AW{1'b0}}) && valid[i] && (waddr[i] == src);
         hit = m ? 1'b1 : hit;
         tn  = m ? tnew[i] : tn;
         sel = m ? SELW'(i + 1) : sel;
      end
      return {hit, tn, sel};
   endfunction

   // Source lookup, hazard detection and forward-select decode.
   always_comb begin
      {hit_rs_s, tnew_rs_s, sel_rs_s} = youngest_match(d_rs, valid_r, waddr_r, tnew_r);
      {hit_rt_s, tnew_rt_s, sel_rt_s} = youngest_match(d_rt, valid_r, waddr_r, tnew_r);
      haz_rs_s     = hit_rs_s && (tnew_rs_s > d_tuse_rs);
      haz_rt_s     = hit_rt_s && (tnew_rt_s > d_tuse_rt);
      fwd_rs_s     = (hit_rs_s && (tnew_rs_s == {TW{1'b0}})) ? sel_rs_s : {SELW{1'b0}};
      fwd_rt_s     = (hit_rt_s && (tnew_rt_s == {TW{1'b0}})) ? sel_rt_s : {SELW{1'b0}};
      stall_base_s = d_valid && (haz_rs_s || haz_rt_s);
      for (int i = 0; i < STAGES; i++) begin
         busy_vec_s[i] = valid_r[i] && (tnew_r[i] != {TW{1'b0}});
      end
   end

`ifdef HAZARD_MDU_EN
   localparam int CW = $clog2(MDU_LAT + 1);
   logic [CW-1:0] mdu_cnt_r;
   logic          md_accept_base_s, md_load_s;

   // The start-in-E term uses the register-hazard stall only, which keeps the stall free of a loop.
   always_comb begin
      md_accept_base_s = md_start && !flush && !stall_base_s;
      stall_s   = stall_base_s ||
                  (d_valid && md_use && ((mdu_cnt_r != {CW{1'b0}}) || md_accept_base_s));
      md_load_s = md_start && !flush && !stall_s;
   end

   // Multiply/divide busy countdown; a running count survives flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mdu_cnt_r <= {CW{1'b0}};
      end else if (md_load_s) begin
         mdu_cnt_r <= CW'(MDU_LAT);
      end else if (mdu_cnt_r != {CW{1'b0}}) begin
         mdu_cnt_r <= mdu_cnt_r - CW'(1);
      end else begin
         mdu_cnt_r <= mdu_cnt_r;
      end
   end

   assign mdu_busy = reset && (mdu_cnt_r != {CW{1'b0}});
`else
   assign stall_s = stall_base_s;
`endif

   assign load_s = !flush && !stall_s && d_valid && (d_waddr != {AW{1'b0}});

   // Entry pipeline: shifts every edge, stall only turns the entry-0 load into a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r <= {STAGES{1'b0}};
         waddr_r <= {(STAGES*AW){1'b0}};
         tnew_r  <= {(STAGES*TW){1'b0}};
      end else begin
         for (int k = 1; k < STAGES; k++) begin
            valid_r[k] <= valid_r[k-1];
            waddr_r[k] <= waddr_r[k-1];
            tnew_r[k]  <= (tnew_r[k-1] != {TW{1'b0}}) ? tnew_r[k-1] - TW'(1) : {TW{1'b0}};
         end
         if (load_s) begin
            valid_r[0] <= 1'b1;
            waddr_r[0] <= d_waddr;
            tnew_r[0]  <= d_tnew;
         end else begin
            valid_r[0] <= 1'b0;
            waddr_r[0] <= {AW{1'b0}};
            tnew_r[0]  <= {TW{1'b0}};
         end
      end
   end

   assign stall      = reset && stall_s;
   assign fwd_sel_rs = reset ? fwd_rs_s : {SELW{1'b0}};
   assign fwd_sel_rt = reset ? fwd_rt_s : {SELW{1'b0}};
   assign busy_any   = reset && (|busy_vec_s);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default 3-stage configuration).
// The multiply/divide sequence is included when HAZARD_MDU_EN is defined.
module tb_hazard_scoreboard;
   localparam int AW = 5;
   localparam int TW = 2;
   localparam int SELW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic            d_valid;
   logic [AW-1:0]   d_rs, d_rt, d_waddr;
   logic [TW-1:0]   d_tuse_rs, d_tuse_rt, d_tnew;
   logic            stall, busy_any;
   logic [SELW-1:0] fwd_sel_rs, fwd_sel_rt;
`ifdef HAZARD_MDU_EN
   logic            md_start, md_use, mdu_busy;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   hazard_scoreboard #(.STAGES(3), .AW(AW), .TW(TW), .SELW(SELW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_waddr(d_waddr), .d_tnew(d_tnew),
`ifdef HAZARD_MDU_EN
      .md_start(md_start), .md_use(md_use), .mdu_busy(mdu_busy),
`endif
      .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .busy_any(busy_any)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic set_d(input logic v, input logic [AW-1:0] rs, input logic [TW-1:0] trs,
                        input logic [AW-1:0] rt, input logic [TW-1:0] trt,
                        input logic [AW-1:0] wa, input logic [TW-1:0] tn);
      d_valid = v; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
      d_waddr = wa; d_tnew = tn;
   endtask

   // Move to just after the next rising edge, then to the following falling edge for sampling.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0;
`ifdef HAZARD_MDU_EN
      md_start = 1'b0; md_use = 1'b0;
`endif
      set_d(1'b1, 5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0);
      repeat (2) @(posedge clk);
      settle();
      check_eq("rst_stall", {31'd0, stall}, 32'd0);
      check_eq("rst_sel_rs", {29'd0, fwd_sel_rs}, 32'd0);
      check_eq("rst_busy", {31'd0, busy_any}, 32'd0);
      reset = 1'b1;

      // Load-use: lw r8 (tnew=1) enters E.
      next_cycle(); set_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 2'd1);
      settle(); check_eq("lw_nostall", {31'd0, stall}, 32'd0);
      next_cycle(); set_d(1'b1, 5'd8, 2'd0, 5'd0, 2'd0, 5'd10, 2'd0);
      settle();
      check_eq("lu_stall", {31'd0, stall}, 32'd1);
      check_eq("lu_sel_rs", {29'd0, fwd_sel_rs}, 32'd0);
      check_eq("lu_busy", {31'd0, busy_any}, 32'd1);
      next_cycle();
      settle();
      check_eq("lu_release", {31'd0, stall}, 32'd0);
      check_eq("lu_fwd_m", {29'd0, fwd_sel_rs}, 32'd2);
      check_eq("lu_busy_clr", {31'd0, busy_any}, 32'd0);

      // ALU back-to-back on rt, plus r8 now in the deepest entry.
      next_cycle(); set_d(1'b1, 5'd8, 2'd0, 5'd10, 2'd1, 5'd9, 2'd0);
      settle();
      check_eq("alu_stall", {31'd0, stall}, 32'd0);
      check_eq("alu_sel_rt", {29'd0, fwd_sel_rt}, 32'd1);
      check_eq("deep_sel_rs", {29'd0, fwd_sel_rs}, 32'd3);

      // Youngest match: r9 written twice in a row.
      next_cycle(); set_d(1'b1, 5'd9, 2'd0, 5'd10, 2'd0, 5'd9, 2'd0);
      settle();
      check_eq("yw_sel_rs_a", {29'd0, fwd_sel_rs}, 32'd1);
      check_eq("yw_sel_rt_a", {29'd0, fwd_sel_rt}, 32'd2);
      next_cycle(); set_d(1'b1, 5'd9, 2'd0, 5'd10, 2'd0, 5'd0, 2'd2);
      settle();
      check_eq("yw_sel_rs", {29'd0, fwd_sel_rs}, 32'd1);
      check_eq("yw_sel_rt", {29'd0, fwd_sel_rt}, 32'd3);

      // $0 immunity: waddr=0 loaded invalid; flush squashes a write to r3.
      next_cycle(); set_d(1'b1, 5'd0, 2'd0, 5'd9, 2'd0, 5'd3, 2'd2); flush = 1'b1;
      settle();
      check_eq("r0_sel_rs", {29'd0, fwd_sel_rs}, 32'd0);
      check_eq("r0_stall", {31'd0, stall}, 32'd0);
      check_eq("w0_sel_rt", {29'd0, fwd_sel_rt}, 32'd2);
      check_eq("w0_busy", {31'd0, busy_any}, 32'd0);
      next_cycle(); flush = 1'b0; set_d(1'b1, 5'd3, 2'd0, 5'd0, 2'd0, 5'd3, 2'd2);
      settle();
      check_eq("fl_stall", {31'd0, stall}, 32'd0);
      check_eq("fl_sel_rs", {29'd0, fwd_sel_rs}, 32'd0);

      // Tnew countdown: r3 tnew=2 vs tuse=1 stalls, then resolved outside, then forwarded.
      next_cycle(); set_d(1'b1, 5'd0, 2'd0, 5'd3, 2'd1, 5'd0, 2'd0);
      settle();
      check_eq("tn2_stall", {31'd0, stall}, 32'd1);
      check_eq("tn2_busy", {31'd0, busy_any}, 32'd1);
      next_cycle();
      settle();
      check_eq("tn1_stall", {31'd0, stall}, 32'd0);
      check_eq("tn1_sel_rt", {29'd0, fwd_sel_rt}, 32'd0);
      check_eq("tn1_busy", {31'd0, busy_any}, 32'd1);
      next_cycle(); set_d(1'b1, 5'd0, 2'd0, 5'd3, 2'd1, 5'd4, 2'd2);
      settle();
      check_eq("tn0_sel_rt", {29'd0, fwd_sel_rt}, 32'd3);
      check_eq("tn0_busy", {31'd0, busy_any}, 32'd0);

      // Mid-operation reset clears everything at once.
      next_cycle(); set_d(1'b1, 5'd4, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
      settle();
      check_eq("pre_rst_stall", {31'd0, stall}, 32'd1);
      check_eq("pre_rst_busy", {31'd0, busy_any}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_busy", {31'd0, busy_any}, 32'd0);
      check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
      #1 reset = 1'b1;
      next_cycle();
      settle();
      check_eq("post_rst_stall", {31'd0, stall}, 32'd0);
      check_eq("post_rst_sel", {29'd0, fwd_sel_rs}, 32'd0);

`ifdef HAZARD_MDU_EN
      // Cycle t: multiply accepted into E.
      next_cycle(); set_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0); md_start = 1'b1; md_use = 1'b0;
      settle();
      check_eq("md_t_busy", {31'd0, mdu_busy}, 32'd0);
      check_eq("md_t_stall", {31'd0, stall}, 32'd0);
      for (int c = 1; c <= 6; c++) begin
         next_cycle(); md_start = 1'b0; md_use = (c >= 3);
         settle();
         check_eq("md_busy", {31'd0, mdu_busy}, (c <= 5) ? 32'd1 : 32'd0);
         check_eq("md_stall", {31'd0, stall}, (c >= 3 && c <= 5) ? 32'd1 : 32'd0);
      end
      md_use = 1'b0;
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
